alu_mc: RTL and testbench

Parametrised multi-cycle ALU, successor to the single-cycle 8-bit combinational ALU in the processor datapath. Adds a configurable data width, registered outputs and flags, and a valid/ready handshake on both sides. Adds two iterative operations: a variable-count left shift and an unsigned shift-add multiply. Sits between the register-file read stage and writeback; the controller stalls on `in_ready`/`out_valid`.

---
 rtl/alu_mc_pkg.sv | 38 +++
 rtl/alu_mc_comb.sv | 64 ++++++
 rtl/alu_mc.sv | 180 ++++++++++++++++++
 tb/tb_alu_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Purpose  : Shared opcode and state definitions for the multi-cycle ALU.
// Contents : C_OP_* opcode constants, alu_cmd_e opcode enum,
//            alu_state_e controller state enum.
// Revision : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

   localparam logic [2:0] C_OP_ADD     = 3'b000;
   localparam logic [2:0] C_OP_SHL     = 3'b001;
   localparam logic [2:0] C_OP_SHR     = 3'b010;
   localparam logic [2:0] C_OP_NAND    = 3'b011;
   localparam logic [2:0] C_OP_SUB     = 3'b100;
   localparam logic [2:0] C_OP_SHLN    = 3'b101;
   localparam logic [2:0] C_OP_MUL     = 3'b110;
   localparam logic [2:0] C_OP_ADD_ALT = 3'b111;

   typedef enum logic [2:0] {
      CMD_ADD     = C_OP_ADD,
      CMD_SHL     = C_OP_SHL,
      CMD_SHR     = C_OP_SHR,
      CMD_NAND    = C_OP_NAND,
      CMD_SUB     = C_OP_SUB,
      CMD_SHLN    = C_OP_SHLN,
      CMD_MUL     = C_OP_MUL,
      CMD_ADD_ALT = C_OP_ADD_ALT
   } alu_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mc_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_comb
// Purpose  : Combinational datapath for the single-cycle ALU operations
//            (ADD/SHL/SHR/NAND/SUB) plus the parity/zero flag logic.
// Ports    : i_cmd, i_a, i_b, i_sc  - opcode, operands, shift/carry in
//            o_rslt, o_sc           - single-cycle result and carry out
//            i_flag_lo/hi, i_flag_mul - value about to be registered
//            o_pari, o_zero         - flags for that value
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc_comb
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       i_cmd,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sc,
   output logic [WIDTH-1:0] o_rslt,
   output logic             o_sc,
   input  logic [WIDTH-1:0] i_flag_lo,
   input  logic [WIDTH-1:0] i_flag_hi,
   input  logic             i_flag_mul,
   output logic             o_pari,
   output logic             o_zero
);

   logic [WIDTH:0] w_ext;
   logic [WIDTH:0] w_cin;

   assign w_cin = {{WIDTH{1'b0}}, i_sc};

   always_comb begin
      w_ext  = '0;
      o_rslt = i_a;
      o_sc   = 1'b0;
      case (alu_cmd_e'(i_cmd))
         CMD_ADD, CMD_ADD_ALT: begin
            w_ext          = {1'b0, i_a} + {1'b0, i_b} + w_cin;
            {o_sc, o_rslt} = w_ext;
         end
         CMD_SHL:  {o_sc, o_rslt} = {i_a, i_sc};
         CMD_SHR:  {o_rslt, o_sc} = {i_sc, i_a};
         CMD_NAND: o_rslt = ~(i_a & i_b);
         CMD_SUB: begin
            w_ext          = {1'b0, i_a} - {1'b0, i_b} + w_cin;
            {o_sc, o_rslt} = w_ext;
         end
         // SHLN with a zero count passes in_a through with no carry out;
         // MUL never loads from here.
         default: begin
            o_rslt = i_a;
            o_sc   = 1'b0;
         end
      endcase
   end

   assign o_pari = ^i_flag_lo;
   assign o_zero = i_flag_mul ? ~|{i_flag_hi, i_flag_lo} : ~|i_flag_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with registered result/flags and valid/ready
//            handshakes. Single-cycle ops come from alu_mc_comb; SHLN and
//            MUL iterate one step per clock in the RUN state.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, alu_cmd, in_a, in_b, sc_i  - request side
//            out_valid/out_ready, rslt, rslt_hi, sc_o, pari, zero - result
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_cmd,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             sc_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic [WIDTH-1:0] rslt_hi,
   output logic             sc_o,
   output logic             pari,
   output logic             zero
);

   // Counter needs one extra bit to hold WIDTH itself for MUL.
   localparam logic [CW:0] C_CNT_FULL = (CW+1)'(WIDTH);
   localparam logic [CW:0] C_CNT_ONE  = (CW+1)'(1);

   alu_state_e         r_state, w_state_nxt;
   logic [CW:0]        r_cnt;
   logic               r_is_mul;
   logic [WIDTH-1:0]   r_sh;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [WIDTH-1:0]   r_rslt, r_rslt_hi;
   logic               r_sc_o, r_pari, r_zero;

   logic [CW:0]        w_k;
   logic               w_is_mul_cmd;
   logic [WIDTH-1:0]   w_c_rslt;
   logic               w_c_sc;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH:0]   w_mul_cat;
   logic [2*WIDTH-1:0] w_acc_step;
   logic [WIDTH-1:0]   w_sh_step;
   logic               w_start, w_load, w_ld_mul, w_ld_sc;
   logic [WIDTH-1:0]   w_ld_rslt, w_ld_hi;
   logic               w_pari, w_zero;

   assign w_k          = {1'b0, in_b[CW-1:0]};
   assign w_is_mul_cmd = (alu_cmd_e'(alu_cmd) == CMD_MUL);

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right by one.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_mplr[0] ? {1'b0, r_mcand} : '0);
   assign w_mul_cat  = {w_mul_sum, r_acc[WIDTH-1:0]};
   assign w_acc_step = w_mul_cat[2*WIDTH:1];
   assign w_sh_step  = r_sh << 1;

   alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
      .i_cmd      (alu_cmd),
      .i_a        (in_a),
      .i_b        (in_b),
      .i_sc       (sc_i),
      .o_rslt     (w_c_rslt),
      .o_sc       (w_c_sc),
      .i_flag_lo  (w_ld_rslt),
      .i_flag_hi  (w_ld_hi),
      .i_flag_mul (w_ld_mul),
      .o_pari     (w_pari),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_ld_rslt   = w_c_rslt;
      w_ld_hi     = '0;
      w_ld_sc     = w_c_sc;
      w_ld_mul    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               if (w_is_mul_cmd ||
                   (alu_cmd_e'(alu_cmd) == CMD_SHLN && w_k != '0)) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (r_cnt == C_CNT_ONE) begin
               w_load      = 1'b1;
               w_state_nxt = ST_DONE;
               if (r_is_mul) begin
                  w_ld_rslt = w_acc_step[WIDTH-1:0];
                  w_ld_hi   = w_acc_step[2*WIDTH-1:WIDTH];
                  w_ld_sc   = |w_acc_step[2*WIDTH-1:WIDTH];
                  w_ld_mul  = 1'b1;
               end else begin
                  w_ld_rslt = w_sh_step;
                  w_ld_sc   = r_sh[WIDTH-1];
               end
            end
         end
         ST_DONE: begin
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_is_mul  <= 1'b0;
         r_sh      <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_rslt    <= '0;
         r_rslt_hi <= '0;
         r_sc_o    <= 1'b0;
         r_pari    <= 1'b0;
         r_zero    <= 1'b1;
      end else begin
         if (w_start) begin
            r_is_mul <= w_is_mul_cmd;
            r_cnt    <= w_is_mul_cmd ? C_CNT_FULL : w_k;
            r_sh     <= in_a;
            r_acc    <= '0;
            r_mcand  <= in_a;
            r_mplr   <= in_b;
         end else if (r_state == ST_RUN) begin
            r_cnt  <= r_cnt - C_CNT_ONE;
            r_sh   <= w_sh_step;
            r_acc  <= w_acc_step;
            r_mplr <= r_mplr >> 1;
         end
         if (w_load) begin
            r_rslt    <= w_ld_rslt;
            r_rslt_hi <= w_ld_hi;
            r_sc_o    <= w_ld_sc;
            r_pari    <= w_pari;
            r_zero    <= w_zero;
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign rslt      = r_rslt;
   assign rslt_hi   = r_rslt_hi;
   assign sc_o      = r_sc_o;
   assign pari      = r_pari;
   assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=8): directed cases,
//            backpressure, reset during MUL, then randomized operations
//            compared with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       alu_cmd = '0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             sc_i = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] rslt, rslt_hi;
   logic             sc_o, pari, zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] r;
      logic [7:0] h;
      logic       sc;
      logic       p;
      logic       z;
      int         lat;
   } exp_t;

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_cmd   (alu_cmd),
      .in_a      (in_a),
      .in_b      (in_b),
      .sc_i      (sc_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rslt      (rslt),
      .rslt_hi   (rslt_hi),
      .sc_o      (sc_o),
      .pari      (pari),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: opcode rules evaluated with integer arithmetic.
   function automatic exp_t model(input logic [2:0] cmd, input logic [7:0] a,
                                  input logic [7:0] b, input logic sc);
      exp_t m;
      int   s, k, p;
      m.r = 0; m.h = 0; m.sc = 0; m.lat = 1;
      case (cmd)
         3'd0, 3'd7: begin
            s = int'(a) + int'(b) + int'(sc);
            m.r = 8'(s & 255); m.sc = ((s >> 8) & 1) != 0;
         end
         3'd1: begin
            s = int'(a) * 2 + int'(sc);
            m.r = 8'(s & 255); m.sc = ((s >> 8) & 1) != 0;
         end
         3'd2: begin
            s = (int'(sc) * 128) + (int'(a) / 2);
            m.r = 8'(s); m.sc = (int'(a) % 2) != 0;
         end
         3'd3: m.r = ~(a & b);
         3'd4: begin
            s = int'(a) - int'(b) + int'(sc);
            m.r = 8'(s & 255); m.sc = ((s >> 8) & 1) != 0;
         end
         3'd5: begin
            k = int'(b) % 8;
            m.r = 8'((int'(a) << k) & 255);
            m.sc = (k != 0) && (((int'(a) >> (8 - k)) & 1) != 0);
            m.lat = k + 1;
         end
         default: begin
            p = int'(a) * int'(b);
            m.r = 8'(p & 255); m.h = 8'(p >> 8);
            m.sc = m.h != 0;
            m.lat = 9;
         end
      endcase
      m.p = ($countones(m.r) % 2) == 1;
      m.z = (cmd == 3'd6) ? ({m.h, m.r} == 16'd0) : (m.r == 8'd0);
      return m;
   endfunction

   task automatic check_outs(input string tag, input exp_t m);
      check({tag, ".rslt"},    32'(rslt),    32'(m.r));
      check({tag, ".rslt_hi"}, 32'(rslt_hi), 32'(m.h));
      check({tag, ".sc_o"},    32'(sc_o),    32'(m.sc));
      check({tag, ".pari"},    32'(pari),    32'(m.p));
      check({tag, ".zero"},    32'(zero),    32'(m.z));
   endtask

   // Wait for out_valid (bounded), counting cycles from the accept edge.
   task automatic wait_result(output int lat);
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (lat >= 40) break;
      end
   endtask

   // Take the result and confirm in_ready comes back the next cycle.
   task automatic take_result(input string tag);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".rdy_after"}, 32'(in_ready),  32'd1);
      check({tag, ".ov_after"},  32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] cmd,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic sc, input int hold);
      exp_t m;
      int   lat;
      m = model(cmd, a, b, sc);
      @(negedge clk);
      check({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; alu_cmd = cmd; in_a = a; in_b = b; sc_i = sc;
      @(posedge clk);
      #1;
      // Keep requesting with junk operands: must be ignored until IDLE.
      alu_cmd = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      sc_i = 1'($urandom);
      wait_result(lat);
      check({tag, ".latency"}, 32'(lat), 32'(m.lat));
      check_outs(tag, m);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_a = 8'($urandom); in_b = 8'($urandom);
         check({tag, ".hold_ov"},  32'(out_valid), 32'd1);
         check({tag, ".hold_rdy"}, 32'(in_ready),  32'd0);
         check_outs({tag, ".hold"}, m);
      end
      take_result(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;
      int   lat;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ov",      32'(out_valid), 32'd0);
      check("rst.rdy",     32'(in_ready),  32'd1);
      check("rst.rslt",    32'(rslt),      32'd0);
      check("rst.rslt_hi", 32'(rslt_hi),   32'd0);
      check("rst.sc_o",    32'(sc_o),      32'd0);
      check("rst.pari",    32'(pari),      32'd0);
      check("rst.zero",    32'(zero),      32'd1);
      rst_n = 1'b1;

      run_op("add_ff01",  3'd0, 8'hFF, 8'h01, 1'b0, 0);
      run_op("sub_0507",  3'd4, 8'h05, 8'h07, 1'b0, 0);
      run_op("mul_ffff",  3'd6, 8'hFF, 8'hFF, 1'b0, 0);
      run_op("mul_zero",  3'd6, 8'h00, 8'h37, 1'b1, 0);
      run_op("shln_k3",   3'd5, 8'hA1, 8'hF3, 1'b0, 0);
      run_op("shln_k0",   3'd5, 8'hA1, 8'h08, 1'b1, 0);
      run_op("shln_k7",   3'd5, 8'hC3, 8'h07, 1'b0, 0);
      run_op("shl",       3'd1, 8'h81, 8'h00, 1'b1, 0);
      run_op("shr",       3'd2, 8'h01, 8'h00, 1'b1, 0);
      run_op("add_alias", 3'd7, 8'h7F, 8'h00, 1'b1, 0);
      run_op("bp_nand",   3'd3, 8'hF0, 8'h3C, 1'b0, 5);

      // Reset in the 4th RUN cycle of a MUL, with a new ADD request held
      // across the reset.
      @(negedge clk);
      in_valid = 1'b1; alu_cmd = 3'd6; in_a = 8'hFF; in_b = 8'hFF; sc_i = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstrun.ov",      32'(out_valid), 32'd0);
      check("rstrun.rdy",     32'(in_ready),  32'd1);
      check("rstrun.rslt",    32'(rslt),      32'd0);
      check("rstrun.rslt_hi", 32'(rslt_hi),   32'd0);
      check("rstrun.sc_o",    32'(sc_o),      32'd0);
      check("rstrun.pari",    32'(pari),      32'd0);
      check("rstrun.zero",    32'(zero),      32'd1);
      in_valid = 1'b1; alu_cmd = 3'd0; in_a = 8'h10; in_b = 8'h20; sc_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      m = model(3'd0, 8'h10, 8'h20, 1'b0);
      wait_result(lat);
      check("post_rst_add.latency", 32'(lat), 32'd1);
      check_outs("post_rst_add", m);
      take_result("post_rst_add");

      for (int i = 0; i < 60; i++) begin
         run_op($sformatf("rnd%0d", i), 3'($urandom), 8'($urandom),
                8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
